// File: rtl/decoder_from_ai.sv
// -----------------------------------------------------------------------------
// decoder_from_ai
//
// Return path of the AI link. Waits for the AI player's turn to start, takes
// the action chosen by the AI core, checks it against the current phase and
// the player's item slots, and emits one-cycle game-controller command
// pulses that stand in for that player's key presses. Invalid actions are
// retried a limited number of times. Silence from the AI falls back to a
// default move. Silence from the game ends the turn with an error.
//
// Parameters:
//   AI_Player  which player (0/1) the AI controls; drives o_player only
//   TIMEOUT_W  width of the response/ack timer
//   TIMEOUT    cycles allowed for the AI response, and separately for the ack
//   MAX_RETRY  invalid actions tolerated per turn before the default is forced
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   i_start          one-cycle pulse: the AI player's turn has begun
//   i_phase_item     game is in the item phase
//   i_phase_shoot    game is in the shoot phase
//   i_state          game FSM state code (a change counts as an ack)
//   i_slot_nonempty  bit k set: AI item slot k holds an item
//   i_cmd_ack        one-cycle pulse: game consumed the command
//   i_ai_valid       AI action valid
//   i_ai_action      0-5 use slot, 6 shoot self, 7 shoot opponent, 8 end item
//   o_ai_ready       block accepts an action (high throughout WAIT_AI)
//   o_use_item       pulse: use item in slot o_item_slot
//   o_item_slot      slot index, held from one issue until the next
//   o_shoot_self     pulse: shoot self
//   o_shoot_opp      pulse: shoot opponent
//   o_end_item       pulse: leave the item phase
//   o_player         constant AI_Player (0 while in reset)
//   o_error          pulse: invalid action, or ack timeout
//   o_timeout        pulse: AI response timeout
//   o_busy           high whenever the FSM is not IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module decoder_from_ai #(
    parameter bit                   AI_Player = 1'b0,
    parameter int                   TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = TIMEOUT_W'(5_000_000),
    parameter int                   MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_phase_item,
    input  logic       i_phase_shoot,
    input  logic [3:0] i_state,
    input  logic [5:0] i_slot_nonempty,
    input  logic       i_cmd_ack,
    input  logic       i_ai_valid,
    input  logic [3:0] i_ai_action,
    output logic       o_ai_ready,
    output logic       o_use_item,
    output logic [2:0] o_item_slot,
    output logic       o_shoot_self,
    output logic       o_shoot_opp,
    output logic       o_end_item,
    output logic       o_player,
    output logic       o_error,
    output logic       o_timeout,
    output logic       o_busy
);

    localparam int                   RETRY_W    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [RETRY_W-1:0]   RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT - TIMEOUT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_AI,
        ISSUE,
        WAIT_ACK
    } state_t;

    typedef struct packed {
        logic use_item;
        logic shoot_self;
        logic shoot_opp;
        logic end_item;
    } pulse_t;

    typedef struct packed {
        pulse_t     pulse;
        logic [2:0] slot;
    } cmd_t;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 phase_item_q, phase_item_d;   // 1: item turn, 0: shoot turn
    logic [3:0]           cap_state_q, cap_state_d;
    pulse_t               pulse_q, pulse_d;
    logic [2:0]           slot_q, slot_d;
    logic                 error_q, error_d;
    logic                 timeout_q, timeout_d;
    logic                 ready_q, busy_q, player_q;

    logic                 handshake;
    logic                 phase_live;
    logic                 action_ok;
    logic [7:0]           slot_map;
    cmd_t                 ai_cmd, dflt_cmd, issue_cmd;
    logic                 issue;

    assign handshake  = i_ai_valid & ready_q;
    // The turn is abandoned as soon as the phase it was started in goes away.
    assign phase_live = phase_item_q ? i_phase_item : i_phase_shoot;
    // Widened so that any 3-bit action index selects a defined bit.
    assign slot_map   = {2'b00, i_slot_nonempty};

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        action_ok = 1'b0;
        ai_cmd    = '0;
        dflt_cmd  = '0;
        if (i_ai_action <= 4'd5) begin
            action_ok              = phase_item_q & slot_map[i_ai_action[2:0]];
            ai_cmd.pulse.use_item  = 1'b1;
            ai_cmd.slot            = i_ai_action[2:0];
        end else if (i_ai_action == 4'd6) begin
            action_ok              = ~phase_item_q;
            ai_cmd.pulse.shoot_self = 1'b1;
        end else if (i_ai_action == 4'd7) begin
            action_ok              = ~phase_item_q;
            ai_cmd.pulse.shoot_opp = 1'b1;
        end else if (i_ai_action == 4'd8) begin
            action_ok              = phase_item_q;
            ai_cmd.pulse.end_item  = 1'b1;
        end
        if (phase_item_q) dflt_cmd.pulse.end_item  = 1'b1;
        else              dflt_cmd.pulse.shoot_opp = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        phase_item_d = phase_item_q;
        cap_state_d  = cap_state_q;
        pulse_d      = '0;
        slot_d       = slot_q;
        error_d      = 1'b0;
        timeout_d    = 1'b0;
        issue        = 1'b0;
        issue_cmd    = '0;

        unique case (state_q)
            IDLE: begin
                if (i_start && (i_phase_item ^ i_phase_shoot)) begin
                    phase_item_d = i_phase_item;
                    timer_d      = '0;
                    retry_d      = '0;
                    state_d      = WAIT_AI;
                end
            end

            WAIT_AI: begin
                timer_d = timer_q + TIMEOUT_W'(1);
                if (!phase_live) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    if (action_ok) begin
                        issue     = 1'b1;
                        issue_cmd = ai_cmd;
                    end else if (retry_q == RETRY_LAST) begin
                        issue     = 1'b1;
                        issue_cmd = dflt_cmd;
                    end else begin
                        error_d = 1'b1;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                // ">=" so an invalid action that wins the timeout cycle only
                // postpones the timeout by one cycle instead of wrapping the timer.
                end else if (timer_q >= TIMER_LAST) begin
                    timeout_d = 1'b1;
                    issue     = 1'b1;
                    issue_cmd = dflt_cmd;
                end
            end

            ISSUE: begin
                cap_state_d = i_state;
                timer_d     = '0;
                state_d     = WAIT_ACK;
            end

            WAIT_ACK: begin
                timer_d = timer_q + TIMEOUT_W'(1);
                if (i_cmd_ack || (i_state != cap_state_q)) begin
                    state_d = IDLE;
                end else if (timer_q >= TIMER_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Command pulses are registered on entry to ISSUE, so they are high
        // exactly during the ISSUE cycle.
        if (issue) begin
            pulse_d = issue_cmd.pulse;
            slot_d  = issue_cmd.slot;
            state_d = ISSUE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            retry_q      <= '0;
            phase_item_q <= 1'b0;
            cap_state_q  <= '0;
            pulse_q      <= '0;
            slot_q       <= '0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            player_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            phase_item_q <= phase_item_d;
            cap_state_q  <= cap_state_d;
            pulse_q      <= pulse_d;
            slot_q       <= slot_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            ready_q      <= (state_d == WAIT_AI);
            busy_q       <= (state_d != IDLE);
            player_q     <= AI_Player;
        end
    end

    assign o_ai_ready   = ready_q;
    assign o_use_item   = pulse_q.use_item;
    assign o_shoot_self = pulse_q.shoot_self;
    assign o_shoot_opp  = pulse_q.shoot_opp;
    assign o_end_item   = pulse_q.end_item;
    assign o_item_slot  = slot_q;
    assign o_player     = player_q;
    assign o_error      = error_q;
    assign o_timeout    = timeout_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_decoder_from_ai.sv
// -----------------------------------------------------------------------------
// tb_decoder_from_ai
//
// Directed bench for decoder_from_ai built with TIMEOUT=16, MAX_RETRY=3 and
// AI_Player=1. Inputs change 1 ns after a rising edge; outputs are sampled at
// the same point, so each check sees the registers loaded by the last edge.
// The eight single-bit outputs are packed into one vector:
//   {use_item, shoot_self, shoot_opp, end_item, error, timeout, ai_ready, busy}
// -----------------------------------------------------------------------------
module tb_decoder_from_ai;

    localparam logic [7:0] P_USE  = 8'h80;
    localparam logic [7:0] P_SELF = 8'h40;
    localparam logic [7:0] P_OPP  = 8'h20;
    localparam logic [7:0] P_END  = 8'h10;
    localparam logic [7:0] P_ERR  = 8'h08;
    localparam logic [7:0] P_TMO  = 8'h04;
    localparam logic [7:0] P_RDY  = 8'h02;
    localparam logic [7:0] P_BSY  = 8'h01;
    localparam logic [7:0] NONE   = 8'h00;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_phase_item;
    logic       i_phase_shoot;
    logic [3:0] i_state;
    logic [5:0] i_slot_nonempty;
    logic       i_cmd_ack;
    logic       i_ai_valid;
    logic [3:0] i_ai_action;
    logic       o_ai_ready;
    logic       o_use_item;
    logic [2:0] o_item_slot;
    logic       o_shoot_self;
    logic       o_shoot_opp;
    logic       o_end_item;
    logic       o_player;
    logic       o_error;
    logic       o_timeout;
    logic       o_busy;
    logic [7:0] outs;

    int n_assert = 0;
    int n_fail   = 0;

    decoder_from_ai #(
        .AI_Player (1'b1),
        .TIMEOUT_W (24),
        .TIMEOUT   (24'd16),
        .MAX_RETRY (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_phase_item    (i_phase_item),
        .i_phase_shoot   (i_phase_shoot),
        .i_state         (i_state),
        .i_slot_nonempty (i_slot_nonempty),
        .i_cmd_ack       (i_cmd_ack),
        .i_ai_valid      (i_ai_valid),
        .i_ai_action     (i_ai_action),
        .o_ai_ready      (o_ai_ready),
        .o_use_item      (o_use_item),
        .o_item_slot     (o_item_slot),
        .o_shoot_self    (o_shoot_self),
        .o_shoot_opp     (o_shoot_opp),
        .o_end_item      (o_end_item),
        .o_player        (o_player),
        .o_error         (o_error),
        .o_timeout       (o_timeout),
        .o_busy          (o_busy)
    );

    assign outs = {o_use_item, o_shoot_self, o_shoot_opp, o_end_item,
                   o_error, o_timeout, o_ai_ready, o_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        i_start         = 1'b0;
        i_phase_item    = 1'b0;
        i_phase_shoot   = 1'b0;
        i_state         = 4'd0;
        i_slot_nonempty = 6'b000000;
        i_cmd_ack       = 1'b0;
        i_ai_valid      = 1'b0;
        i_ai_action     = 4'd0;

        // ---- reset state ----
        tick();
        tick();
        check("reset_outs", outs, NONE);
        check("reset_slot", o_item_slot, 3'd0);
        check("reset_player", o_player, 1'b0);
        rst = 1'b0;
        tick();
        check("player_tag", o_player, 1'b1);
        check("idle_outs", outs, NONE);

        // ---- item phase: action 2 on the 3rd WAIT_AI cycle ----
        i_phase_item    = 1'b1;
        i_slot_nonempty = 6'b000100;
        i_state         = 4'd1;
        i_start         = 1'b1;
        tick();
        i_start = 1'b0;
        check("t1_wait_ai_c1", outs, P_RDY | P_BSY);
        tick();
        check("t1_wait_ai_c2", outs, P_RDY | P_BSY);
        tick();
        i_ai_valid  = 1'b1;
        i_ai_action = 4'd2;
        tick();
        i_ai_valid = 1'b0;
        check("t1_issue_use", outs, P_USE | P_BSY);
        check("t1_issue_slot", o_item_slot, 3'd2);
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        check("t1_ack_in_issue_ignored", outs, P_BSY);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("t1_start_while_busy_ignored", outs, P_BSY);
        tick();
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        check("t1_acked_idle", outs, NONE);
        check("t1_slot_held", o_item_slot, 3'd2);

        // ---- start with both / neither phase flag is ignored ----
        i_phase_shoot = 1'b1;
        i_start       = 1'b1;
        tick();
        check("start_both_flags", outs, NONE);
        i_phase_item  = 1'b0;
        i_phase_shoot = 1'b0;
        tick();
        i_start = 1'b0;
        check("start_no_flags", outs, NONE);

        // ---- shoot phase: action 7, ack by state change 2->5 ----
        i_phase_shoot = 1'b1;
        i_state       = 4'd2;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
        check("t2_wait_ai", outs, P_RDY | P_BSY);
        i_ai_valid  = 1'b1;
        i_ai_action = 4'd7;
        tick();
        i_ai_valid = 1'b0;
        check("t2_issue_opp", outs, P_OPP | P_BSY);
        tick();
        check("t2_wait_ack", outs, P_BSY);
        i_state = 4'd5;
        tick();
        check("t2_state_change_idle", outs, NONE);

        // ---- item phase retries: 7, 4 (empty slot), 12 ----
        i_phase_shoot   = 1'b0;
        i_phase_item    = 1'b1;
        i_slot_nonempty = 6'b000100;
        i_state         = 4'd1;
        i_start         = 1'b1;
        tick();
        i_start = 1'b0;
        check("t3_wait_ai", outs, P_RDY | P_BSY);
        i_ai_valid  = 1'b1;
        i_ai_action = 4'd7;
        tick();
        check("t3_err_after_7", outs, P_ERR | P_RDY | P_BSY);
        i_ai_action = 4'd4;
        tick();
        check("t3_err_after_4", outs, P_ERR | P_RDY | P_BSY);
        i_ai_action = 4'd12;
        tick();
        i_ai_valid = 1'b0;
        check("t3_forced_end_item", outs, P_END | P_BSY);
        i_state = 4'd2;
        tick();
        check("t3_wait_ack", outs, P_BSY);
        i_state = 4'd3;
        tick();
        check("t3_idle", outs, NONE);

        // ---- shoot phase: AI silent -> timeout, then no ack -> error ----
        i_phase_item  = 1'b0;
        i_phase_shoot = 1'b1;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
        check("t4_wait_ai_first", outs, P_RDY | P_BSY);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("t4_wait_ai_%0d", i), outs, P_RDY | P_BSY);
        end
        tick();
        check("t4_timeout_default_opp", outs, P_TMO | P_OPP | P_BSY);
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("t4_wait_ack_%0d", i), outs, P_BSY);
        end
        tick();
        check("t4_ack_timeout_error", outs, P_ERR);
        tick();
        check("t4_idle", outs, NONE);

        // ---- valid action in the timeout cycle wins ----
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        check("t4b_last_wait_cycle", outs, P_RDY | P_BSY);
        i_ai_valid  = 1'b1;
        i_ai_action = 4'd6;
        tick();
        i_ai_valid = 1'b0;
        check("t4b_handshake_beats_timeout", outs, P_SELF | P_BSY);
        tick();
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        check("t4b_idle", outs, NONE);

        // ---- phase flag drops during WAIT_AI ----
        i_phase_shoot = 1'b0;
        i_phase_item  = 1'b1;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        check("t5_wait_ai", outs, P_RDY | P_BSY);
        i_phase_item = 1'b0;
        tick();
        check("t5_phase_drop_idle", outs, NONE);
        tick();
        check("t5_stays_idle", outs, NONE);

        // ---- highest slot index ----
        i_phase_item    = 1'b1;
        i_slot_nonempty = 6'b100000;
        i_start         = 1'b1;
        tick();
        i_start     = 1'b0;
        i_ai_valid  = 1'b1;
        i_ai_action = 4'd5;
        tick();
        i_ai_valid = 1'b0;
        check("t7_issue_use5", outs, P_USE | P_BSY);
        check("t7_slot5", o_item_slot, 3'd5);
        tick();
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        check("t7_idle", outs, NONE);

        // ---- async reset mid-WAIT_AI, then a fresh turn ----
        i_phase_item  = 1'b0;
        i_phase_shoot = 1'b1;
        i_start       = 1'b1;
        tick();
        i_start     = 1'b0;
        i_ai_valid  = 1'b1;
        i_ai_action = 4'd8;
        tick();
        i_ai_valid = 1'b0;
        check("t6_err_before_rst", outs, P_ERR | P_RDY | P_BSY);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_rst_outs", outs, NONE);
        check("t6_async_rst_slot", o_item_slot, 3'd0);
        check("t6_async_rst_player", o_player, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_after_rst_player", o_player, 1'b1);
        check("t6_after_rst_idle", outs, NONE);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("t6_fresh_wait_ai", outs, P_RDY | P_BSY);
        i_ai_valid  = 1'b1;
        i_ai_action = 4'd8;
        tick();
        check("t6_retry1_err", outs, P_ERR | P_RDY | P_BSY);
        tick();
        check("t6_retry2_err", outs, P_ERR | P_RDY | P_BSY);
        tick();
        i_ai_valid = 1'b0;
        check("t6_forced_opp", outs, P_OPP | P_BSY);
        tick();
        i_cmd_ack = 1'b1;
        tick();
        i_cmd_ack = 1'b0;
        check("t6_idle", outs, NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
